// File: rtl/adc_frame_capture_if.sv
// Sample stream interface of the ADC frame capture engine.
//   sample_data   captured sample (producer -> consumer)
//   sample_ch     channel that produced sample_data (producer -> consumer)
//   sample_valid  sample_data/sample_ch hold a sample (producer -> consumer)
//   sample_ready  consumer accepts when valid & ready (consumer -> producer)
interface adc_frame_capture_if #(
    parameter int unsigned DATA_BITS = 12,
    parameter int unsigned CH_BITS   = 2
);
    logic [DATA_BITS-1:0] sample_data;
    logic [CH_BITS-1:0]   sample_ch;
    logic                 sample_valid;
    logic                 sample_ready;

    modport master (
        output sample_data,
        output sample_ch,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_ch,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/adc_frame_capture.sv
// SPI-style ADC capture engine. Generates SCLK from CLOCK_50, frames each transfer with cs_n,
// shifts the channel address out on mosi (MSB first) and the sample in on miso, then presents
// the last DATA_BITS received bits on a valid/ready stream. Single-shot (start) or continuous
// round-robin scanning (cont) over NUM_CH channels.
// Ports:
//   CLOCK_50     in   system clock, rising edge
//   reset        in   synchronous, active-high
//   start        in   one-cycle pulse, capture one frame (honoured in idle only)
//   cont         in   continuous frames while held
//   sclk         out  ADC serial clock
//   cs_n         out  ADC chip select, active-low
//   mosi         out  channel address, MSB first
//   miso         in   ADC serial data
//   overrun      out  sticky: an unaccepted sample was overwritten
//   clr_overrun  in   clears overrun
//   busy         out  high whenever a frame or gap is in progress
//   smp          sample stream (master): sample_data/sample_ch/sample_valid out, sample_ready in
module adc_frame_capture #(
    parameter int unsigned SCLK_DIV   = 4,
    parameter int unsigned FRAME_BITS = 16,
    parameter int unsigned DATA_BITS  = 12,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CH_BITS    = 2,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                start,
    input  logic                cont,
    output logic                sclk,
    output logic                cs_n,
    output logic                mosi,
    input  logic                miso,
    output logic                overrun,
    input  logic                clr_overrun,
    output logic                busy,
    adc_frame_capture_if.master smp
);
    localparam int unsigned DivW = $clog2(SCLK_DIV);
    localparam int unsigned BitW = $clog2(FRAME_BITS);
    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [DivW-1:0]    DivLast = DivW'(SCLK_DIV - 1);
    localparam logic [DivW-1:0]    DivHalf = DivW'(SCLK_DIV / 2);
    localparam logic [BitW-1:0]    BitLast = BitW'(FRAME_BITS - 1);
    localparam logic [GapW-1:0]    GapLast = GapW'(GAP_CYCLES - 1);
    localparam logic [CH_BITS-1:0] ChLast  = CH_BITS'(NUM_CH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } state_e;

    state_e               r_state;
    logic [DivW-1:0]      r_div;
    logic [BitW-1:0]      r_bit;
    logic [GapW-1:0]      r_gap;
    logic [CH_BITS-1:0]   r_frame_ch;
    logic [CH_BITS-1:0]   r_ch_ptr;
    logic [DATA_BITS-1:0] r_rx;
    logic                 r_sclk;
    logic                 r_cs_n;
    logic                 r_mosi;
    logic [DATA_BITS-1:0] r_data;
    logic [CH_BITS-1:0]   r_ch;
    logic                 r_valid;
    logic                 r_overrun;

    state_e               w_state_nxt;
    logic [DivW-1:0]      w_div_nxt;
    logic [BitW-1:0]      w_bit_nxt;
    logic [GapW-1:0]      w_gap_nxt;
    logic [CH_BITS-1:0]   w_frame_ch_nxt;
    logic                 w_mosi_nxt;
    logic [DATA_BITS-1:0] w_rx_nxt;
    logic                 w_frame_done;
    logic                 w_sample_now;

    assign w_frame_done = (r_state == StShift) && (r_div == DivLast) && (r_bit == BitLast);
    assign w_sample_now = (r_state == StShift) && (r_div == DivHalf);
    // With SCLK_DIV=2 the last miso sample and the frame end coincide, so load from the
    // post-shift value.
    assign w_rx_nxt = w_sample_now ? {r_rx[DATA_BITS-2:0], miso} : r_rx;

    always_comb begin
        w_state_nxt    = r_state;
        w_div_nxt      = r_div;
        w_bit_nxt      = r_bit;
        w_gap_nxt      = r_gap;
        w_frame_ch_nxt = r_frame_ch;
        unique case (r_state)
            StIdle: begin
                if (start || cont) begin
                    w_state_nxt    = StShift;
                    w_div_nxt      = '0;
                    w_bit_nxt      = '0;
                    w_frame_ch_nxt = r_ch_ptr;
                end
            end
            StShift: begin
                if (r_div == DivLast) begin
                    w_div_nxt = '0;
                    if (r_bit == BitLast) begin
                        w_state_nxt = StGap;
                        w_gap_nxt   = '0;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            StGap: begin
                if (r_gap == GapLast) begin
                    if (cont) begin
                        w_state_nxt    = StShift;
                        w_div_nxt      = '0;
                        w_bit_nxt      = '0;
                        // Pointer was already advanced on entry to the gap.
                        w_frame_ch_nxt = r_ch_ptr;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Pin outputs are registered from next-state values so they are glitch-free yet change in
    // the same cycle as the state they decode.
    always_comb begin
        w_mosi_nxt = 1'b0;
        if (w_state_nxt == StShift) begin
            if (w_div_nxt == '0) begin
                for (int b = 0; b < CH_BITS; b++) begin
                    if (w_bit_nxt == BitW'(b)) begin
                        w_mosi_nxt = w_frame_ch_nxt[CH_BITS-1-b];
                    end
                end
            end else begin
                w_mosi_nxt = r_mosi;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state    <= StIdle;
            r_div      <= '0;
            r_bit      <= '0;
            r_gap      <= '0;
            r_frame_ch <= '0;
            r_ch_ptr   <= '0;
            r_rx       <= '0;
            r_sclk     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_mosi     <= 1'b0;
            r_data     <= '0;
            r_ch       <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_div      <= w_div_nxt;
            r_bit      <= w_bit_nxt;
            r_gap      <= w_gap_nxt;
            r_frame_ch <= w_frame_ch_nxt;
            r_rx       <= w_rx_nxt;
            r_sclk     <= (w_state_nxt == StShift) && (w_div_nxt >= DivHalf);
            r_cs_n     <= (w_state_nxt != StShift);
            r_mosi     <= w_mosi_nxt;

            // A load in the same cycle as an accept wins: valid stays high with new data.
            if (w_frame_done) begin
                r_data   <= w_rx_nxt;
                r_ch     <= r_frame_ch;
                r_valid  <= 1'b1;
                r_ch_ptr <= (r_frame_ch == ChLast) ? '0 : r_frame_ch + 1'b1;
            end else if (r_valid && smp.sample_ready) begin
                r_valid <= 1'b0;
            end

            if (w_frame_done && r_valid && !smp.sample_ready) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign sclk             = r_sclk;
    assign cs_n             = r_cs_n;
    assign mosi             = r_mosi;
    assign overrun          = r_overrun;
    assign busy             = (r_state != StIdle);
    assign smp.sample_data  = r_data;
    assign smp.sample_ch    = r_ch;
    assign smp.sample_valid = r_valid;
endmodule

// File: tb/tb_adc_frame_capture.sv
// Self-checking bench for adc_frame_capture: default-parameter instance plus a small
// SCLK_DIV=2 / FRAME_BITS=12 / NUM_CH=1 instance. ADC models push expected samples into
// scoreboard queues when a frame starts; monitors pop and compare on accepted samples.
module tb_adc_frame_capture;
    localparam int unsigned FrameCyc = 64;
    localparam int unsigned Period   = 66;

    logic CLOCK_50;
    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    int unsigned cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    logic reset = 1'b1, start = 1'b0, cont = 1'b0, clr_overrun = 1'b0, miso = 1'b0;
    logic sclk, cs_n, mosi, overrun, busy;
    logic start2 = 1'b0, cont2 = 1'b0, clr2 = 1'b0, miso2 = 1'b0;
    logic sclk2, cs2_n, mosi2, overrun2, busy2;

    adc_frame_capture_if #(.DATA_BITS(12), .CH_BITS(2)) s_if ();
    adc_frame_capture_if #(.DATA_BITS(12), .CH_BITS(1)) s2_if ();

    adc_frame_capture u_dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .start       (start),
        .cont        (cont),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .miso        (miso),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .busy        (busy),
        .smp         (s_if)
    );

    adc_frame_capture #(
        .SCLK_DIV   (2),
        .FRAME_BITS (12),
        .DATA_BITS  (12),
        .NUM_CH     (1),
        .CH_BITS    (1),
        .GAP_CYCLES (2)
    ) u_dut2 (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .start       (start2),
        .cont        (cont2),
        .sclk        (sclk2),
        .cs_n        (cs2_n),
        .mosi        (mosi2),
        .miso        (miso2),
        .overrun     (overrun2),
        .clr_overrun (clr2),
        .busy        (busy2),
        .smp         (s2_if)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    // ---------------- ADC model and monitors, default instance ----------------
    logic [11:0] next_data = 12'hABC;
    logic [15:0] adc_word;
    int unsigned adc_idx = 0;
    int unsigned exp_ch = 0;
    logic [1:0]  frame_ch_exp;
    logic [13:0] sb_q[$];
    logic [13:0] sb_top;
    logic [15:0] mosi_bits;
    int unsigned n_sclk = 0;

    always @(negedge cs_n) begin
        adc_word     = {4'hD, next_data};
        adc_idx      = 0;
        miso         = adc_word[15];
        frame_ch_exp = exp_ch[1:0];
        sb_q.push_back({exp_ch[1:0], next_data});
        exp_ch       = (exp_ch + 1) % 4;
        next_data    = next_data + 12'h135;
        mosi_bits    = '0;
        n_sclk       = 0;
    end

    always @(negedge sclk) begin
        if (!cs_n && adc_idx < 15) begin
            adc_idx++;
            miso = adc_word[15-adc_idx];
        end
    end

    always @(posedge sclk) begin
        if (!cs_n) begin
            mosi_bits = {mosi_bits[14:0], mosi};
            n_sclk++;
        end
    end

    logic        prev_cs_n = 1'b1;
    int unsigned low_len = 0, high_len = 0, last_fall = 0, n_fall = 0, n_acc = 0;
    bit          chk_frame = 1'b1, chk_gap = 1'b0, have_prev = 1'b0;

    always @(negedge CLOCK_50) begin
        if (prev_cs_n && !cs_n) begin
            n_fall++;
            if (chk_gap && have_prev) begin
                check_eq("gap_len", high_len, 2);
                check_eq("frame_period", cyc - last_fall, Period);
            end
            have_prev = chk_gap;
            last_fall = cyc;
            low_len   = 0;
        end
        if (!prev_cs_n && cs_n) begin
            if (chk_frame) begin
                check_eq("cs_low_len", low_len, FrameCyc);
                check_eq("sclk_rises", n_sclk, 16);
                check_eq("mosi_bits", mosi_bits, {frame_ch_exp, 14'b0});
            end
            high_len = 0;
        end
        if (!cs_n) low_len++;
        else       high_len++;
        prev_cs_n = cs_n;

        if (s_if.sample_valid && s_if.sample_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_depth", sb_q.size(), 1);
            end else begin
                sb_top = sb_q.pop_front();
                check_eq("sample_ch", s_if.sample_ch, sb_top[13:12]);
                check_eq("sample_data", s_if.sample_data, sb_top[11:0]);
            end
            n_acc++;
        end
    end

    // ---------------- ADC model and monitor, small instance ----------------
    logic [11:0] next2 = 12'hF5A;
    logic [11:0] adc2_word;
    int unsigned adc2_idx = 0;
    logic [11:0] sb2_q[$];
    logic [11:0] sb2_top;
    logic        prev2 = 1'b1;
    int unsigned low2_len = 0, n2_fall = 0, n2_acc = 0, n2_mosi_hi = 0, last2_fall = 0;
    bit          have_prev2 = 1'b0;

    always @(negedge cs2_n) begin
        adc2_word = next2;
        adc2_idx  = 0;
        miso2     = adc2_word[11];
        sb2_q.push_back(next2);
        next2     = {next2[10:0], next2[11]} ^ 12'h801;
    end

    always @(negedge sclk2) begin
        if (!cs2_n && adc2_idx < 11) begin
            adc2_idx++;
            miso2 = adc2_word[11-adc2_idx];
        end
    end

    always @(negedge CLOCK_50) begin
        if (prev2 && !cs2_n) begin
            n2_fall++;
            if (have_prev2) check_eq("d2_period", cyc - last2_fall, 26);
            have_prev2 = 1'b1;
            last2_fall = cyc;
            low2_len   = 0;
        end
        if (!prev2 && cs2_n) check_eq("d2_cs_low_len", low2_len, 24);
        if (!cs2_n) low2_len++;
        if (!cs2_n && mosi2) n2_mosi_hi++;
        prev2 = cs2_n;

        if (s2_if.sample_valid && s2_if.sample_ready) begin
            if (sb2_q.size() == 0) begin
                check_eq("d2_sb_depth", sb2_q.size(), 1);
            end else begin
                sb2_top = sb2_q.pop_front();
                check_eq("d2_sample_ch", s2_if.sample_ch, 0);
                check_eq("d2_sample_data", s2_if.sample_data, sb2_top);
            end
            n2_acc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, cyc %0d", cyc);
        $fatal(1);
    end

    // ---------------- Stimulus ----------------
    int unsigned c0, t1, base_f, base_a;

    initial begin
        s_if.sample_ready  = 1'b1;
        s2_if.sample_ready = 1'b1;
        tick(3);
        check_eq("rst_cs_n", cs_n, 1);
        check_eq("rst_sclk", sclk, 0);
        check_eq("rst_mosi", mosi, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", s_if.sample_valid, 0);
        check_eq("rst_overrun", overrun, 0);
        check_eq("rst_data", s_if.sample_data, 0);
        check_eq("rst_ch", s_if.sample_ch, 0);
        reset = 1'b0;
        tick(2);

        // Single frame: latency, data, gap then idle.
        start = 1'b1;
        c0    = cyc;
        tick(1);
        start = 1'b0;
        check_eq("t1_cs_low", cs_n, 0);
        check_eq("t1_busy", busy, 1);
        for (int i = 0; i < 100 && !s_if.sample_valid; i++) tick(1);
        check_eq("t1_latency", cyc - c0, 65);
        check_eq("t1_data", s_if.sample_data, 12'hABC);
        check_eq("t1_ch", s_if.sample_ch, 0);
        check_eq("t1_busy_gap0", busy, 1);
        tick(1);
        check_eq("t1_busy_gap1", busy, 1);
        tick(1);
        check_eq("t1_busy_idle", busy, 0);
        check_eq("t1_cs_idle", cs_n, 1);

        // Reset mid-frame at bit 7 of a channel-1 frame.
        chk_frame = 1'b0;
        start     = 1'b1;
        c0        = cyc;
        tick(1);
        start = 1'b0;
        tick(29);
        reset = 1'b1;
        tick(1);
        check_eq("t2_cs_n", cs_n, 1);
        check_eq("t2_sclk", sclk, 0);
        check_eq("t2_busy", busy, 0);
        check_eq("t2_valid", s_if.sample_valid, 0);
        check_eq("t2_data", s_if.sample_data, 0);
        reset = 1'b0;
        sb_q.delete();
        exp_ch = 0;
        tick(2);
        chk_frame = 1'b1;

        // Continuous scan, six frames: channels 0,1,2,3,0,1.
        chk_gap = 1'b1;
        base_f  = n_fall;
        base_a  = n_acc;
        cont    = 1'b1;
        for (int i = 0; i < 7 * Period && n_fall < base_f + 6; i++) tick(1);
        cont = 1'b0;
        for (int i = 0; i < 200 && busy; i++) tick(1);
        check_eq("t3_idle", busy, 0);
        check_eq("t3_frames", n_fall - base_f, 6);
        check_eq("t3_samples", n_acc - base_a, 6);
        check_eq("t3_overrun", overrun, 0);
        chk_gap = 1'b0;

        // Back-pressure: hold, same-cycle load+accept, overwrite -> overrun, clear.
        s_if.sample_ready = 1'b0;
        cont              = 1'b1;
        for (int i = 0; i < 100 && !s_if.sample_valid; i++) tick(1);
        check_eq("t4_first_valid", s_if.sample_valid, 1);
        t1 = cyc;
        tick(30);
        check_eq("t4_held_valid", s_if.sample_valid, 1);
        check_eq("t4_held_data", s_if.sample_data, sb_q[0][11:0]);
        tick(35);
        s_if.sample_ready = 1'b1;
        tick(1);
        s_if.sample_ready = 1'b0;
        check_eq("t4_load_accept_valid", s_if.sample_valid, 1);
        check_eq("t4_load_accept_ovr", overrun, 0);
        check_eq("t4_load_accept_data", s_if.sample_data, sb_q[0][11:0]);
        for (int i = 0; i < 100 && !overrun; i++) tick(1);
        cont = 1'b0;
        check_eq("t4_overrun", overrun, 1);
        check_eq("t4_overrun_time", cyc - t1, 2 * Period);
        check_eq("t4_q_depth", sb_q.size(), 2);
        sb_q.delete(0);
        check_eq("t4_overwrite_data", s_if.sample_data, sb_q[0][11:0]);
        clr_overrun = 1'b1;
        tick(1);
        clr_overrun = 1'b0;
        check_eq("t4_clr_overrun", overrun, 0);
        check_eq("t4_clr_valid", s_if.sample_valid, 1);
        s_if.sample_ready = 1'b1;
        for (int i = 0; i < 100 && busy; i++) tick(1);
        tick(1);
        check_eq("t4_idle", busy, 0);
        check_eq("t4_q_empty", sb_q.size(), 0);

        // cont dropped mid-frame, start during SHIFT ignored.
        base_f = n_fall;
        base_a = n_acc;
        cont   = 1'b1;
        tick(20);
        cont  = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int i = 0; i < 150 && busy; i++) tick(1);
        check_eq("t5_idle", busy, 0);
        check_eq("t5_samples", n_acc - base_a, 1);
        tick(80);
        check_eq("t5_frames", n_fall - base_f, 1);
        check_eq("t5_cs_n", cs_n, 1);

        // Small instance: 24-cycle frames, channel 0, full 12-bit data.
        cont2 = 1'b1;
        for (int i = 0; i < 200 && n2_fall < 3; i++) tick(1);
        cont2 = 1'b0;
        for (int i = 0; i < 100 && busy2; i++) tick(1);
        tick(1);
        check_eq("d2_idle", busy2, 0);
        check_eq("d2_samples", n2_acc, 3);
        check_eq("d2_mosi_zero", n2_mosi_hi, 0);
        check_eq("d2_overrun", overrun2, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
